mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised MEM pipeline stage for the 16-bit pipelined processor. It sits between the EX/MEM and MEM/WB registers and performs these functions:
- resolves BEQZ/BNEZ branches;
- drives a variable-latency data memory through a req/ready handshake with a timeout watchdog;
- selects the write-back result (ALU, sign-extended immediate, or load data);
- holds the MEM/WB register under stall and flush.

While a memory access is outstanding it raises a stall to the hazard unit. A completed access is never re-issued while the downstream stage is frozen.

## Interface
Parameters:
- DATA_WIDTH, 16, datapath width
- ADDR_WIDTH, 8, PC and data-memory address width
- IMM_WIDTH, 8, immediate width (≤ DATA_WIDTH, ≤ ADDR_WIDTH)
- REG_WIDTH, 4, register index width
- WAIT_LIMIT, 15, maximum memory wait cycles before timeout (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM holds a live instruction
- PCM_i  in  ADDR_WIDTH  instruction PC
- alu_outM_i  in  DATA_WIDTH  ALU result
- WriteDataM_i  in  DATA_WIDTH  store data / branch operand from EX/MEM
- ResultW_i  in  DATA_WIDTH  WB result for forwarding
- fwd_sel_i  in  1  1: use ResultW_i as store/branch operand
- immM_i  in  IMM_WIDTH  immediate
- WriteRegM_i  in  REG_WIDTH  destination register
- RegWriteM_i, BranchM_i, BranchNeM_i, MemReadM_i, MemWriteM_i, MovM_i, AddrModeM_i  in  1 each  controls; AddrMode 0 = immediate address, 1 = alu_outM_i address
- stall_i  in  1  freeze MEM/WB (downstream stall)
- flush_i  in  1  load a bubble into MEM/WB
- dm_req_o  out  1  memory request
- dm_we_o  out  1  write enable (valid with dm_req_o)
- dm_addr_o  out  ADDR_WIDTH  address
- dm_wdata_o  out  DATA_WIDTH  write data
- dm_rdata_i  in  DATA_WIDTH  read data, valid when dm_ready_i=1
- dm_ready_i  in  1  memory completes access this cycle
- stall_o  out  1  MEM busy; upstream must hold EX/MEM
- PC_src_o  out  1  branch taken
- branchAddr_o  out  ADDR_WIDTH  branch target
- WBResult_o  out  DATA_WIDTH  MEM/WB result
- WriteReg_o  out  REG_WIDTH  MEM/WB destination
- RegWrite_o  out  1  MEM/WB write enable
- err_o  out  1  sticky timeout flag

## Operation
- Operand: op = fwd_sel_i ? ResultW_i : WriteDataM_i. dm_wdata_o = op.
- Branch (combinational): PC_src_o = valid_i & BranchM_i & (BranchNeM_i ? op≠0 : op==0). branchAddr_o = PCM_i + sign-extend(immM_i) to ADDR_WIDTH, modulo 2^ADDR_WIDTH.
- Address: dm_addr_o = AddrModeM_i ? alu_outM_i[ADDR_WIDTH-1:0] : zero-extend(immM_i).
- access = valid_i & (MemReadM_i | MemWriteM_i). dm_we_o = MemWriteM_i.
- FSM states:
  - IDLE
    - dm_req_o = access.
    - If access & dm_ready_i: complete. If stall_i=1, capture dm_rdata_i into buffer and go to HELD; otherwise stay in IDLE.
    - If access & !dm_ready_i: go to WAIT, cnt=1.
  - WAIT
    - dm_req_o = 1.
    - On dm_ready_i, complete as in IDLE.
    - Otherwise, if cnt==WAIT_LIMIT, time out: complete with rdata=0 and set err_o.
    - Otherwise cnt++.
  - HELD
    - dm_req_o = 0. Access is done; hold the buffer.
    - Leave for IDLE when stall_i=0.
- stall_o = (IDLE & access & !dm_ready_i) | (WAIT & !dm_ready_i & cnt≠WAIT_LIMIT).
- Result: res = MemReadM_i ? load data (dm_rdata_i, buffer in HELD, 0 on timeout) : MovM_i ? sign-extend(immM_i) : alu_outM_i.
- MEM/WB update, in priority order:
  1. rst: all MEM/WB outputs 0.
  2. flush_i: RegWrite_o←0; other fields don't-care, held.
  3. stall_i: hold.
  4. stall_o: load bubble (RegWrite_o←0).
  5. Otherwise: load res, WriteRegM_i, and RegWriteM_i & valid_i.
- Reset mid-access: FSM→IDLE, cnt→0, buffer→0, err_o→0. dm_req_o is 0 in the cycle after rst when access=0.
- err_o stays at 1 until rst.

## Timing
- Reset values: WBResult_o=0, WriteReg_o=0, RegWrite_o=0, err_o=0, FSM=IDLE.
- Zero-wait memory (ready in the request cycle): no stall; result appears at MEM/WB on the next edge.
- N wait cycles: stall_o is high for N cycles, and MEM/WB loads in the cycle after ready.
- Timeout: stall_o is high for WAIT_LIMIT cycles. MEM/WB receives 0, and err_o rises on the same edge.
- HELD covers an access completed while stall_i=1. There is exactly one request per instruction, and the buffered data reaches MEM/WB on the first edge with stall_i=0.
- Simultaneous flush_i and completion: the bubble wins and the FSM still returns to IDLE/HELD normally.
- PC_src_o and branchAddr_o are combinational, with no added latency.

## Test plan
- Zero-wait load: AddrMode=0, imm=0x12, memory returns 0xBEEF with ready in the same cycle → stall_o never asserts; next edge WBResult_o=0xBEEF, RegWrite_o=1.
- Three-wait store: ready on the 4th request cycle → stall_o high 3 cycles; dm_req_o and dm_we_o steady for 4 cycles; exactly one write; RegWrite_o=0 bubbles during the stall.
- Timeout, WAIT_LIMIT=15, ready never → stall_o high 15 cycles; WBResult_o=0; err_o=1, still 1 after 10 further cycles; cleared only by rst.
- Completion under stall_i=1 for 5 cycles → dm_req_o drops after completion and is not reissued; WBResult_o updates on the first edge after stall_i=0.
- Branch: PC=0xF0, imm=0x20 (+32), op=0, BEQZ → PC_src_o=1, branchAddr_o=0x10 (wrap). Same with imm=0xFE → 0xEE. BNEZ with op=0 → PC_src_o=0.
- rst asserted during WAIT (cycle 2 of 5) → next cycle dm_req_o=0, all MEM/WB outputs 0, FSM=IDLE; a new access issues normally afterwards.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: branch resolution, data-memory handshake with timeout,
// write-back result selection and the MEM/WB register.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   valid_i           - EX/MEM holds a live instruction
//   PCM_i, immM_i     - PC and immediate (branch target, address, MOV value)
//   alu_outM_i        - ALU result (address in AddrMode 1, default result)
//   WriteDataM_i      - store data / branch operand
//   ResultW_i         - forwarded WB result, selected by fwd_sel_i
//   WriteRegM_i       - destination register
//   *M_i controls     - RegWrite, Branch, BranchNe, MemRead, MemWrite, Mov,
//                       AddrMode
//   stall_i, flush_i  - freeze / bubble the MEM/WB register
//   dm_*              - data memory req/ready interface
//   stall_o           - memory access outstanding, hold EX/MEM
//   PC_src_o          - branch taken; branchAddr_o is its target
//   WBResult_o, WriteReg_o, RegWrite_o - MEM/WB register
//   err_o             - sticky memory timeout flag
module mem_access_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IMM_WIDTH  = 8,
    parameter int REG_WIDTH  = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic                  fwd_sel_i,
    input  logic [IMM_WIDTH-1:0]  immM_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  BranchNeM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MovM_i,
    input  logic                  AddrModeM_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  dm_req_o,
    output logic                  dm_we_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    output logic [DATA_WIDTH-1:0] dm_wdata_o,
    input  logic [DATA_WIDTH-1:0] dm_rdata_i,
    input  logic                  dm_ready_i,
    output logic                  stall_o,
    output logic                  PC_src_o,
    output logic [ADDR_WIDTH-1:0] branchAddr_o,
    output logic [DATA_WIDTH-1:0] WBResult_o,
    output logic [REG_WIDTH-1:0]  WriteReg_o,
    output logic                  RegWrite_o,
    output logic                  err_o
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

    state_t                state, stateNext;
    logic [CW-1:0]         cnt, cntNext;
    logic [DATA_WIDTH-1:0] buffer, bufferNext;
    logic                  errNext;
    logic                  access, complete;
    logic [DATA_WIDTH-1:0] op, loadData, res;
    logic [DATA_WIDTH-1:0] immSxD;
    logic [ADDR_WIDTH-1:0] immSxA, immZxA;

    // Immediate extensions, written so IMM_WIDTH may equal the target width.
    always_comb begin
        immSxD = {DATA_WIDTH{immM_i[IMM_WIDTH-1]}};
        immSxD[IMM_WIDTH-1:0] = immM_i;
        immSxA = {ADDR_WIDTH{immM_i[IMM_WIDTH-1]}};
        immSxA[IMM_WIDTH-1:0] = immM_i;
        immZxA = '0;
        immZxA[IMM_WIDTH-1:0] = immM_i;
    end

    assign op           = fwd_sel_i ? ResultW_i : WriteDataM_i;
    assign dm_wdata_o   = op;
    assign dm_we_o      = MemWriteM_i;
    assign dm_addr_o    = AddrModeM_i ? alu_outM_i[ADDR_WIDTH-1:0] : immZxA;
    assign access       = valid_i & (MemReadM_i | MemWriteM_i);
    assign branchAddr_o = PCM_i + immSxA;
    assign PC_src_o     = valid_i & BranchM_i
                        & (BranchNeM_i ? (op != '0) : (op == '0));

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bufferNext = buffer;
        errNext    = err_o;
        dm_req_o   = 1'b0;
        stall_o    = 1'b0;
        complete   = 1'b0;
        loadData   = dm_rdata_i;
        unique case (state)
            IDLE: begin
                dm_req_o = access;
                if (access) begin
                    if (dm_ready_i) begin
                        complete = 1'b1;
                    end else begin
                        stall_o   = 1'b1;
                        stateNext = WAIT;
                        cntNext   = CW'(1);
                    end
                end
            end
            WAIT: begin
                dm_req_o = 1'b1;
                if (dm_ready_i) begin
                    complete = 1'b1;
                end else if (cnt == LIMIT) begin
                    // Timeout completes the access with zero data.
                    complete = 1'b1;
                    loadData = '0;
                    errNext  = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cntNext = cnt + CW'(1);
                end
            end
            HELD: begin
                loadData = buffer;
                if (!stall_i) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // A completion under downstream stall parks the data so the
        // request is not issued a second time.
        if (complete) begin
            cntNext = '0;
            if (stall_i) begin
                stateNext  = HELD;
                bufferNext = loadData;
            end else begin
                stateNext = IDLE;
            end
        end
    end

    assign res = MemReadM_i ? loadData : (MovM_i ? immSxD : alu_outM_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            buffer <= '0;
            err_o  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            buffer <= bufferNext;
            err_o  <= errNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WBResult_o <= '0;
            WriteReg_o <= '0;
            RegWrite_o <= 1'b0;
        end else if (flush_i) begin
            RegWrite_o <= 1'b0;
        end else if (stall_i) begin
            RegWrite_o <= RegWrite_o;
        end else if (stall_o) begin
            RegWrite_o <= 1'b0;
        end else begin
            WBResult_o <= res;
            WriteReg_o <= WriteRegM_i;
            RegWrite_o <= RegWriteM_i & valid_i;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: transaction-level model of
// latency, stalls, results, branches and the sticky timeout flag.
module tb_mem_access_unit;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int IW = 8;
    localparam int RW = 4;
    localparam int WL = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [AW-1:0] PCM_i;
    logic [DW-1:0] alu_outM_i;
    logic [DW-1:0] WriteDataM_i;
    logic [DW-1:0] ResultW_i;
    logic          fwd_sel_i;
    logic [IW-1:0] immM_i;
    logic [RW-1:0] WriteRegM_i;
    logic          RegWriteM_i, BranchM_i, BranchNeM_i;
    logic          MemReadM_i, MemWriteM_i, MovM_i, AddrModeM_i;
    logic          stall_i, flush_i;
    logic          dm_req_o, dm_we_o;
    logic [AW-1:0] dm_addr_o;
    logic [DW-1:0] dm_wdata_o;
    logic [DW-1:0] dm_rdata_i;
    logic          dm_ready_i;
    logic          stall_o, PC_src_o;
    logic [AW-1:0] branchAddr_o;
    logic [DW-1:0] WBResult_o;
    logic [RW-1:0] WriteReg_o;
    logic          RegWrite_o, err_o;

    mem_access_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMM_WIDTH(IW),
        .REG_WIDTH(RW), .WAIT_LIMIT(WL)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .PCM_i(PCM_i),
        .alu_outM_i(alu_outM_i), .WriteDataM_i(WriteDataM_i),
        .ResultW_i(ResultW_i), .fwd_sel_i(fwd_sel_i), .immM_i(immM_i),
        .WriteRegM_i(WriteRegM_i), .RegWriteM_i(RegWriteM_i),
        .BranchM_i(BranchM_i), .BranchNeM_i(BranchNeM_i),
        .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
        .MovM_i(MovM_i), .AddrModeM_i(AddrModeM_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i),
        .dm_ready_i(dm_ready_i), .stall_o(stall_o), .PC_src_o(PC_src_o),
        .branchAddr_o(branchAddr_o), .WBResult_o(WBResult_o),
        .WriteReg_o(WriteReg_o), .RegWrite_o(RegWrite_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v, br, bne, rd, wr, mov, am, rw, fwd;
        int pc, alu, wd, resw, imm, wreg;
    } instr_t;

    int checks = 0;
    int errors = 0;
    int mem [256];
    bit errExp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sext8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic instr_t idleInstr();
        instr_t i;
        i = '{default: 0};
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        int k;
        i = '{default: 0};
        i.v    = ($urandom_range(0, 7) != 0);
        k      = $urandom_range(0, 5);
        i.rd   = (k == 0 || k == 1);
        i.wr   = (k == 2);
        i.mov  = (k == 3);
        i.br   = (k == 4);
        i.bne  = $urandom_range(0, 1);
        i.am   = $urandom_range(0, 1);
        i.rw   = $urandom_range(0, 1);
        i.fwd  = $urandom_range(0, 1);
        i.pc   = $urandom_range(0, 255);
        i.alu  = $urandom_range(0, 65535);
        i.wd   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535);
        i.resw = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 65535);
        i.imm  = $urandom_range(0, 255);
        i.wreg = $urandom_range(0, 15);
        return i;
    endfunction

    task automatic drive(input instr_t i);
        valid_i      = i.v;
        PCM_i        = AW'(i.pc);
        alu_outM_i   = DW'(i.alu);
        WriteDataM_i = DW'(i.wd);
        ResultW_i    = DW'(i.resw);
        fwd_sel_i    = i.fwd;
        immM_i       = IW'(i.imm);
        WriteRegM_i  = RW'(i.wreg);
        RegWriteM_i  = i.rw;
        BranchM_i    = i.br;
        BranchNeM_i  = i.bne;
        MemReadM_i   = i.rd;
        MemWriteM_i  = i.wr;
        MovM_i       = i.mov;
        AddrModeM_i  = i.am;
    endtask

    // lat: wait cycles before ready; sLen: cycles of downstream stall from
    // the start; fl: flush on the cycle the instruction leaves MEM.
    task automatic doInstr(input instr_t i, input int lat, input int sLen,
                           input bit fl);
        int op, addr, stc, last, reqs, stalls, wrs, expRes, expReqs;
        bit acc, tmo, taken, bubble;
        op     = i.fwd ? i.resw : i.wd;
        acc    = i.v && (i.rd || i.wr);
        tmo    = acc && (lat > WL);
        stc    = acc ? ((lat < WL) ? lat : WL) : 0;
        last   = (stc > sLen) ? stc : sLen;
        addr   = i.am ? (i.alu & 255) : i.imm;
        expRes = i.rd ? (tmo ? 0 : mem[addr])
               : (i.mov ? (sext8(i.imm) & 16'hFFFF) : i.alu);
        taken  = i.v && i.br && (i.bne ? (op != 0) : (op == 0));
        expReqs = !acc ? 0 : (tmo ? WL + 1 : lat + 1);
        reqs = 0;
        stalls = 0;
        wrs = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            drive(i);
            stall_i    = (c < sLen);
            flush_i    = fl && (c == last);
            dm_ready_i = 1'b0;
            dm_rdata_i = DW'($urandom);
            #1;
            if (c == 0) begin
                check("pc_src", PC_src_o, taken);
                check("br_addr", branchAddr_o, (i.pc + sext8(i.imm)) & 255);
                if (acc) begin
                    check("addr", dm_addr_o, addr);
                    check("wdata", dm_wdata_o, op);
                    check("we", dm_we_o, i.wr);
                end
            end
            if (dm_req_o) begin
                reqs++;
                if (reqs == lat + 1) begin
                    dm_ready_i = 1'b1;
                    dm_rdata_i = DW'(mem[addr]);
                end
            end
            #1;
            if (stall_o) stalls++;
            if (c == last) check("stall_end", stall_o, 0);
            if (dm_req_o && dm_we_o && dm_ready_i) begin
                wrs++;
                mem[addr] = op;
            end
            bubble = stall_o && !stall_i && !flush_i;
            @(posedge clk);
            #1;
            if (bubble) check("bubble", RegWrite_o, 0);
        end
        check("reqs", reqs, expReqs);
        check("stalls", stalls, stc);
        check("writes", wrs, (i.wr && acc && !tmo) ? 1 : 0);
        errExp = errExp | tmo;
        check("err", err_o, errExp);
        check("regwrite", RegWrite_o, i.rw && i.v && !fl);
        if (!fl) begin
            check("wreg", WriteReg_o, i.wreg);
            if (!(i.rd && !acc)) check("result", WBResult_o, expRes);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        drive(idleInstr());
        stall_i = 1'b0;
        flush_i = 1'b0;
        dm_ready_i = 1'b0;
        @(posedge clk);
        #1;
        errExp = 1'b0;
        check("rst_req", dm_req_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_wb", WBResult_o, 0);
        check("rst_wreg", WriteReg_o, 0);
        check("rst_rw", RegWrite_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        instr_t i;
        rst = 1'b1;
        drive(idleInstr());
        stall_i = 1'b0;
        flush_i = 1'b0;
        dm_ready_i = 1'b0;
        dm_rdata_i = '0;
        for (int a = 0; a < 256; a++) mem[a] = $urandom_range(0, 65535);
        repeat (2) @(posedge clk);
        doReset();

        // Zero-wait load from immediate address 0x12.
        mem[8'h12] = 16'hBEEF;
        i = idleInstr();
        i.v = 1; i.rd = 1; i.rw = 1; i.imm = 8'h12; i.wreg = 3;
        doInstr(i, 0, 0, 0);
        check("beef", WBResult_o, 16'hBEEF);

        // Three-wait store.
        i = idleInstr();
        i.v = 1; i.wr = 1; i.am = 1; i.alu = 16'h0044; i.wd = 16'h1234;
        doInstr(i, 3, 0, 0);
        check("store_mem", mem[8'h44], 16'h1234);

        // Completion under five cycles of downstream stall.
        i = idleInstr();
        i.v = 1; i.rd = 1; i.rw = 1; i.imm = 8'h12; i.wreg = 5;
        doInstr(i, 0, 5, 0);

        // Branches: wrap forward, negative offset, BNEZ not taken.
        i = idleInstr();
        i.v = 1; i.br = 1; i.pc = 8'hF0; i.imm = 8'h20;
        doInstr(i, 0, 0, 0);
        i.imm = 8'hFE;
        doInstr(i, 0, 0, 0);
        i.bne = 1;
        doInstr(i, 0, 0, 0);

        // Ready exactly on the last allowed cycle, then a timeout.
        i = idleInstr();
        i.v = 1; i.rd = 1; i.rw = 1; i.imm = 8'h12;
        doInstr(i, WL, 0, 0);
        doInstr(i, 40, 0, 0);
        for (int k = 0; k < 10; k++) doInstr(idleInstr(), 0, 0, 0);
        check("err_sticky", err_o, 1);
        doReset();

        // Reset during the wait phase of a load.
        @(negedge clk);
        i = idleInstr();
        i.v = 1; i.rd = 1; i.rw = 1; i.imm = 8'h30;
        drive(i);
        repeat (2) @(negedge clk);
        doReset();
        i.imm = 8'h12;
        doInstr(i, 1, 0, 0);

        for (int n = 0; n < 250; n++) begin
            int lat;
            lat = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) lat = WL;
            if ($urandom_range(0, 15) == 0) lat = WL + $urandom_range(1, 4);
            doInstr(randInstr(), lat,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                    ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
